sdot_seq: RTL and testbench

SDOT_SEQ -- requirements
Module: sdot_seq

---
 rtl/smul_pkg.sv | 15 +
 rtl/sdot_seq_sacc.sv | 40 ++++
 rtl/sdot_seq.sv | 103 ++++++++++
 tb/tb_sdot_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/smul_pkg.sv
// Shared types and widths for the signed dot-product sequencer.
package smul_pkg;

  localparam int MUL_W         = 4;
  localparam int PROD_W        = 8;
  localparam int ACC_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/sdot_seq_sacc.sv
// Dot-product accumulator and term counter; cleared once a result is consumed.
module sacc
  import smul_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add_en,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  acc,
  output logic              last
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  logic [CNT_W-1:0] term_cnt;
  logic [ACC_W-1:0] product_ext;

  assign product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      term_cnt <= '0;
    end else if (clr) begin
      acc      <= '0;
      term_cnt <= '0;
    end else if (add_en) begin
      acc      <= acc + product_ext;
      term_cnt <= term_cnt + 1'b1;
    end
  end

  // Evaluated before the increment, so it flags the final term of a result.
  assign last = (term_cnt == CNT_W'(N_TERMS - 1));

endmodule

// File: rtl/sdot_seq.sv
// Signed dot-product sequencer driving an external shift-add multiplier.
// state | meaning: IDLE accept pair | ISSUE start pulse | WAIT await product | OUT hold result
module sdot_seq
  import smul_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_W-1:0]  in_a,
  input  logic [MUL_W-1:0]  in_b,
  output logic              mul_start,
  output logic [MUL_W-1:0]  mul_word1,
  output logic [MUL_W-1:0]  mul_word2,
  input  logic [PROD_W-1:0] mul_product,
  input  logic              mul_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum
);

  state_t           state, state_nxt;
  logic [MUL_W-1:0] op_a, op_b;
  logic             wait_first;
  logic             accept, done, clr, last;
  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op_a       <= '0;
      op_b       <= '0;
      wait_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_first <= (state == ST_ISSUE);
      if (accept) begin
        op_a <= in_a;
        op_b <= in_b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by reset so nothing is offered while the multiplier is held.
        in_ready = mul_ready & reset;
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // mul_ready still reflects the previous idle state in the first cycle.
        if (!wait_first && mul_ready) begin
          done      = 1'b1;
          state_nxt = last ? ST_OUT : ST_IDLE;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clr       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mul_word1 = op_a;
  assign mul_word2 = op_b;
  assign out_sum   = out_valid ? acc : '0;

  sacc #(
    .N_TERMS(N_TERMS),
    .ACC_W  (ACC_W)
  ) u_sacc (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .add_en (done),
    .product(mul_product),
    .acc    (acc),
    .last   (last)
  );

endmodule

// File: tb/tb_sdot_seq.sv
// Directed bench: two sequencers (4 and 8 terms), each paired with a shift-add multiplier model.
module tb_sdot_seq;

  logic        clk;
  logic        rst_n;
  logic        mul_rst;
  logic [1:0]  iv, ir, orr, ov;
  logic [3:0]  ia [2];
  logic [3:0]  ib [2];
  logic [11:0] osum [2];
  logic [1:0]  m_start, m_ready;
  logic [3:0]  m_w1 [2];
  logic [3:0]  m_w2 [2];
  logic [7:0]  m_prod [2];

  int checks = 0;
  int errors = 0;

  int starts0 = 0, accepts0 = 0, consec0 = 0;
  logic prev_start0 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_rst = ~rst_n;

  sdot_seq #(.N_TERMS(4), .ACC_W(12)) u_dut4 (
    .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .mul_start(m_start[0]), .mul_word1(m_w1[0]), .mul_word2(m_w2[0]), .mul_product(m_prod[0]),
    .mul_ready(m_ready[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_sum(osum[0])
  );

  sdot_seq #(.N_TERMS(8), .ACC_W(12)) u_dut8 (
    .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
    .mul_start(m_start[1]), .mul_word1(m_w1[1]), .mul_word2(m_w2[1]), .mul_product(m_prod[1]),
    .mul_ready(m_ready[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_sum(osum[1])
  );

  // Shift-add signed multiplier: one multiplier bit per cycle, 4 busy cycles, MSB weight negative.
  for (genvar g = 0; g < 2; g++) begin : g_mul
    logic [2:0] cnt;
    logic [7:0] prod, a_ext, part;
    logic [3:0] b_r;
    logic [1:0] idx;
    assign idx  = 2'(3'd4 - cnt);
    assign part = b_r[idx] ? (a_ext << idx) : 8'd0;
    always_ff @(posedge clk or posedge mul_rst) begin
      if (mul_rst) begin
        cnt <= '0; prod <= '0; a_ext <= '0; b_r <= '0;
      end else if (m_start[g]) begin
        cnt   <= 3'd4;
        prod  <= '0;
        a_ext <= {{4{m_w1[g][3]}}, m_w1[g]};
        b_r   <= m_w2[g];
      end else if (cnt != 3'd0) begin
        prod <= (idx == 2'd3) ? prod - part : prod + part;
        cnt  <= cnt - 1'b1;
      end
    end
    assign m_ready[g] = (cnt == 3'd0);
    assign m_prod[g]  = prod;
  end

  always @(posedge clk) begin
    if (m_start[0]) starts0++;
    if (m_start[0] && prev_start0) consec0++;
    if (iv[0] && ir[0]) accepts0++;
    prev_start0 = m_start[0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Feeds n pairs (nibble k of av/bv is pair k) and returns cycles from first accept to out_valid.
  task automatic drive(input int d, input logic [31:0] av, input logic [31:0] bv, input int n,
                       output int lat);
    int k = 0;
    int cyc = 0;
    int first = -1;
    lat = -1;
    while (cyc < 400) begin
      @(negedge clk);
      if (ov[d]) begin
        lat = cyc - first;
        break;
      end
      if (k < n) begin
        iv[d] = 1'b1;
        ia[d] = av[4*k +: 4];
        ib[d] = bv[4*k +: 4];
      end else begin
        iv[d] = 1'b0;
      end
      #1;
      if (iv[d] && ir[d]) begin
        if (first < 0) first = cyc;
        k++;
      end
      cyc++;
    end
    iv[d] = 1'b0;
  endtask

  task automatic consume(input int d);
    orr[d] = 1'b1;
    @(negedge clk);
    orr[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ir !== 2'b00) begin errors++; $display("FAIL reset_in_ready got %b want 00", ir); end
    checks++; if (m_start !== 2'b00) begin errors++; $display("FAIL reset_mul_start got %b want 00", m_start); end
    checks++; if (ov !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b want 00", ov); end
    checks++; if (osum[0] !== 12'h000) begin errors++; $display("FAIL reset_out_sum got %h want 000", osum[0]); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dot4;
    int lat;
    int s0 = starts0, a0 = accepts0;
    drive(0, 32'h0000_78F3, 32'h0000_8842, 4, lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL dot4_latency got %0d want 28", lat); end
    checks++; if (osum[0] !== 12'h00A) begin errors++; $display("FAIL dot4_sum got %h want 00a", osum[0]); end
    checks++; if (accepts0 - a0 !== 4) begin errors++; $display("FAIL dot4_accepts got %0d want 4", accepts0 - a0); end
    checks++; if (starts0 - s0 !== 4) begin errors++; $display("FAIL dot4_starts got %0d want 4", starts0 - s0); end
  endtask

  task automatic test_hold;
    int lat;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ov[0] !== 1'b1 || osum[0] !== 12'h00A || ir[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got ov=%b sum=%h ir=%b want ov=1 sum=00a ir=0", i, ov[0], osum[0], ir[0]);
      end
      @(negedge clk);
    end
    consume(0);
    #1;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL hold_release_ov got %b want 0", ov[0]); end
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL hold_release_ir got %b want 1", ir[0]); end
    drive(0, 32'h0000_E012, 32'h0000_E5F3, 4, lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL after_hold_latency got %0d want 28", lat); end
    checks++; if (osum[0] !== 12'h009) begin errors++; $display("FAIL after_hold_sum got %h want 009", osum[0]); end
    consume(0);
  endtask

  task automatic test_dot8;
    int lat;
    drive(1, 32'h8888_8888, 32'h8888_8888, 8, lat);
    checks++; if (lat !== 56) begin errors++; $display("FAIL dot8_neg_latency got %0d want 56", lat); end
    checks++; if (osum[1] !== 12'h200) begin errors++; $display("FAIL dot8_neg_sum got %h want 200", osum[1]); end
    consume(1);
    drive(1, 32'h8888_8888, 32'h7777_7777, 8, lat);
    checks++; if (lat !== 56) begin errors++; $display("FAIL dot8_mix_latency got %0d want 56", lat); end
    checks++; if (osum[1] !== 12'hE40) begin errors++; $display("FAIL dot8_mix_sum got %h want e40", osum[1]); end
    consume(1);
  endtask

  task automatic test_reset_mid;
    int lat;
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; ia[0] = 4'd5; ib[0] = 4'd5;
      #1;
      if (ir[0]) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL midreset_first_accept got none want accept"); end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    iv[0] = 1'b0;
    #1;
    checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b want 0", ir[0]); end
    checks++; if (m_start[0] !== 1'b0) begin errors++; $display("FAIL midreset_mul_start got %b want 0", m_start[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", ov[0]); end
    checks++; if (osum[0] !== 12'h000) begin errors++; $display("FAIL midreset_out_sum got %h want 000", osum[0]); end
    checks++; if (m_w1[0] !== 4'h0) begin errors++; $display("FAIL midreset_operand got %h want 0", m_w1[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0000_1111, 32'h0000_1111, 4, lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL postreset_latency got %0d want 28", lat); end
    checks++; if (osum[0] !== 12'h004) begin errors++; $display("FAIL postreset_sum got %h want 004", osum[0]); end
    consume(0);
  endtask

  task automatic test_random_valid;
    int s0 = starts0, a0 = accepts0, c0 = consec0;
    orr[0] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      iv[0] = 1'($urandom_range(0, 1));
      ia[0] = 4'd1; ib[0] = 4'd1;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    orr[0] = 1'b0;
    checks++; if (consec0 - c0 !== 0) begin errors++; $display("FAIL rand_consec_start got %0d want 0", consec0 - c0); end
    checks++; if (starts0 - s0 !== accepts0 - a0) begin
      errors++; $display("FAIL rand_start_count got %0d want %0d", starts0 - s0, accepts0 - a0);
    end
    checks++; if (accepts0 - a0 < 30) begin errors++; $display("FAIL rand_accepts got %0d want >=30", accepts0 - a0); end
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0; orr = '0;
    ia[0] = '0; ib[0] = '0; ia[1] = '0; ib[1] = '0;
    test_reset();
    test_dot4();
    test_hold();
    test_dot8();
    test_reset_mid();
    test_random_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
